pingpong_frame_buffer: RTL

PINGPONG_FRAME_BUFFER -- requirements
Module: pingpong_frame_buffer

---
 rtl/fb_defs.sv | 35 +++
 rtl/fb_dpram.sv | 37 +++
 rtl/pingpong_frame_buffer.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fb_defs.sv
// Shared definitions for the ping-pong frame buffer: pixel format codes,
// stored pixel width, controller state encoding and the RGB packing helper.
package fb_defs;

  localparam int FMT_RGB444 = 0;
  localparam int FMT_RGB565 = 1;
  localparam int FMT_RGB888 = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SWAP_WAIT = 2'd1,
    ST_CLEAR     = 2'd2
  } fb_state_e;

  function automatic int pix_bits(input int fmt);
    case (fmt)
      FMT_RGB444: return 12;
      FMT_RGB565: return 16;
      default:    return 24;
    endcase
  endfunction

  // Result is right-aligned in 24 bits; callers keep the low pix_bits(fmt) bits.
  function automatic logic [23:0] pack_pixel(input int fmt, input logic [23:0] rgb);
    logic [23:0] packed_pix;
    packed_pix = '0;
    case (fmt)
      FMT_RGB444: packed_pix = {12'd0, rgb[23:20], rgb[15:12], rgb[7:4]};
      FMT_RGB565: packed_pix = {8'd0, rgb[23:19], rgb[15:10], rgb[7:3]};
      default:    packed_pix = rgb;
    endcase
    return packed_pix;
  endfunction

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port frame store: one write port, one read port with a
// registered output that holds its value when no read is requested.
module fb_dpram #(
  parameter int DW = 24,
  parameter int AW = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reset only touches the output register; the array contents survive.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/pingpong_frame_buffer.sv
// Double-buffered frame store: the writer fills the back bank while the display
// reads the front bank; banks swap at vertical blank after the writer finishes.
module pingpong_frame_buffer
  import fb_defs::*;
#(
  parameter int          WIDTH       = 640,
  parameter int          HEIGHT      = 480,
  parameter int          ADDR_WIDTH  = 19,
  parameter int          PIX_FMT     = 0,
  parameter logic [23:0] CLEAR_COLOR = 24'h000000,
  localparam int         PIX_BITS    = fb_defs::pix_bits(PIX_FMT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [23:0]           wr_data,
  input  logic                  wr_frame_done,
  input  logic                  clear_req,
  input  logic                  rd_frame_start,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [PIX_BITS-1:0]   rd_data,
  output logic                  rd_valid,
  output logic                  front_bank,
  output logic                  busy,
  output logic                  addr_err,
  output logic [1:0]            dbg_state
);

  localparam int unsigned            NPIX       = WIDTH * HEIGHT;
  localparam logic [ADDR_WIDTH:0]    NPIX_W     = (ADDR_WIDTH+1)'(NPIX);
  localparam logic [ADDR_WIDTH-1:0]  LAST_IDX   = ADDR_WIDTH'(NPIX - 1);
  localparam logic [23:0]            CLEAR_FULL = pack_pixel(PIX_FMT, CLEAR_COLOR);
  localparam logic [PIX_BITS-1:0]    CLEAR_PIX  = CLEAR_FULL[PIX_BITS-1:0];

  fb_state_e               r_state;
  logic                    r_front_bank;
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic                    r_addr_err;
  logic                    r_wr_ready;
  logic                    r_busy;
  logic                    r_rd_valid;

  logic [23:0]             w_pack_full;
  logic [PIX_BITS-1:0]     w_pack;
  logic                    w_wr_fire;
  logic                    w_in_range;
  logic                    w_ram_we;
  logic [ADDR_WIDTH:0]     w_ram_waddr;
  logic [PIX_BITS-1:0]     w_ram_wdata;
  logic [ADDR_WIDTH:0]     w_ram_raddr;

  // Handshake: a write transfers on any rising edge where wr_valid and wr_ready
  // are both high; wr_ready is high exactly while the controller is idle.
  assign w_wr_fire   = wr_valid & r_wr_ready;
  assign w_in_range  = ({1'b0, wr_addr} < NPIX_W);
  assign w_pack_full = pack_pixel(PIX_FMT, wr_data);
  assign w_pack      = w_pack_full[PIX_BITS-1:0];
  assign w_ram_raddr = {r_front_bank, rd_addr};

  // Writes always land in the back bank, so they never collide with reads.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = {~r_front_bank, wr_addr};
    w_ram_wdata = w_pack;
    if (!rst) begin
      if (r_state == ST_CLEAR) begin
        w_ram_we    = 1'b1;
        w_ram_waddr = {~r_front_bank, r_clr_cnt};
        w_ram_wdata = CLEAR_PIX;
      end else if (w_wr_fire && w_in_range) begin
        w_ram_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_front_bank <= 1'b0;
      r_clr_cnt    <= '0;
      r_addr_err   <= 1'b0;
      r_wr_ready   <= 1'b1;
      r_busy       <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (w_wr_fire && !w_in_range) begin
        r_addr_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (clear_req) begin
            r_state    <= ST_CLEAR;
            r_clr_cnt  <= '0;
            r_wr_ready <= 1'b0;
            r_busy     <= 1'b1;
          end else if (wr_frame_done && rd_frame_start) begin
            r_front_bank <= ~r_front_bank;
          end else if (wr_frame_done) begin
            r_state    <= ST_SWAP_WAIT;
            r_wr_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_SWAP_WAIT: begin
          if (rd_frame_start) begin
            r_front_bank <= ~r_front_bank;
            r_state      <= ST_IDLE;
            r_wr_ready   <= 1'b1;
            r_busy       <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (r_clr_cnt == LAST_IDX) begin
            r_clr_cnt  <= '0;
            r_state    <= ST_IDLE;
            r_wr_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wr_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  fb_dpram #(
    .DW(PIX_BITS),
    .AW(ADDR_WIDTH + 1)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (rd_en),
    .i_raddr (w_ram_raddr),
    .o_rdata (rd_data)
  );

  assign wr_ready   = r_wr_ready;
  assign busy       = r_busy;
  assign rd_valid   = r_rd_valid;
  assign front_bank = r_front_bank;
  assign addr_err   = r_addr_err;
  assign dbg_state  = r_state;

endmodule
